fetch_unit: RTL and testbench

- Instruction fetch front end that sits directly upstream of the single-cycle core's decode/execute path.
- Owns the fetch PC and issues in-order requests to an instruction memory over a valid/ready request channel.
- Buffers returned instruction words, each paired with its PC, in a small prefetch FIFO.
- Presents them to the core over a valid/ready channel; handles branch/jump redirects by flushing the FIFO and discarding in-flight responses.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem requests, buffers {instr, pc} in a prefetch FIFO.
// Latency: request accepted in cycle N, 1-cycle memory returns in N+1, instruction visible to the core in N+2 (no bypass).
// Backpressure: credit based; requests stop while outstanding + buffered == DEPTH and resume the cycle after a pop frees one.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        request channel to instruction memory (addr held while stalled)
//   imem_resp_valid/data             in-order response channel, no backpressure
//   redirect_valid/pc                taken branch/jump from the core; flushes FIFO, drops in-flight responses
//   instr_valid/ready, instr/pc      FIFO head presented to the core; data and pc read 0 when not valid
module fetch_unit #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam int              PW      = $clog2(DEPTH);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;

  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];

  logic [CW:0]     credit_sum;
  logic [XLEN-1:0] redir_tgt;
  logic            req_fire;
  logic            resp_acc;
  logic            resp_keep;
  logic            pop;

  // Masking rather than slicing keeps every redirect_pc bit in use.
  assign redir_tgt  = redirect_pc & ~(XLEN'(3));

  // Outstanding requests each own a FIFO slot, so the FIFO can never overflow.
  assign credit_sum     = {1'b0, outst_q} + {1'b0, count_q};
  assign imem_req_valid = !reset && (credit_sum < DEPTH_C) && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a leftover from before reset.
  assign resp_acc  = imem_resp_valid && (outst_q != '0);
  assign resp_keep = resp_acc && (drop_q == '0) && !redirect_valid;

  assign instr_valid = !reset && (count_q != '0);
  assign instr       = instr_valid ? data_mem_q[head_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem_q[head_q]   : '0;
  assign pop         = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(resp_acc);

    if (redirect_valid) begin
      // Everything still in flight belongs to the old path; req_fire is 0 here,
      // so outst_d already reflects a same-cycle response.
      fetch_pc_d = redir_tgt;
      resp_pc_d  = redir_tgt;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      drop_d     = outst_q - CW'(resp_acc);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (resp_acc && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (resp_keep) begin
        tail_d    = tail_q + PW'(1);
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(resp_keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (resp_keep) begin
      data_mem_q[tail_q] <= imem_resp_data;
      pc_mem_q[tail_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int lat     = 1;
  int last_due = -1;
  bit rand_lat = 1'b0;

  // memory model pipeline and scoreboard of expected delivered PCs
  int          q_due[$];
  logic [31:0] q_addr[$];
  logic [31:0] exp_q[$];

  // per-cycle snapshot taken mid low phase
  logic        s_rv, s_iv, s_fire, s_pop;
  logic [31:0] s_addr, s_pc, s_instr, s_pop_pc;

  typedef struct packed {
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
  endtask

  // One clock cycle: drive memory response, sample, run models, advance past posedge.
  task automatic step();
    int          due;
    int          l;
    logic [31:0] a;
    logic [31:0] e;
    @(negedge clk);
    if (q_due.size() != 0 && q_due[0] <= cyc) begin
      due = q_due.pop_front();
      a   = q_addr.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = a ^ K;
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    s_rv    = imem_req_valid;
    s_addr  = imem_req_addr;
    s_iv    = instr_valid;
    s_pc    = instr_pc;
    s_instr = instr;
    s_fire  = imem_req_valid && imem_req_ready;
    s_pop   = instr_valid && instr_ready && !redirect_valid && !reset;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (s_fire) begin
        l   = rand_lat ? int'($urandom_range(1, 3)) : lat;
        due = cyc + l;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        q_due.push_back(due);
        q_addr.push_back(imem_req_addr);
        exp_q.push_back(imem_req_addr);
      end
      if (redirect_valid) exp_q.delete();
      if (s_pop) begin
        s_pop_pc = instr_pc;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: delivered pc %h, expected nothing", instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", instr_pc, e);
          chk("sb_instr", instr, e ^ K);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    repeat (n) step();
    reset    = 1'b0;
    cyc      = 0;
    last_due = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first;
    int npop;
    int nreq;
    logic [31:0] first_pc;
    logic [31:0] prev_addr;
    bit prev_stall;

    // backpressure vectors: 1-cycle memory, imem always ready
    //            ir    rv    addr    iv    pc
    tbl[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h4};
    tbl[12] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h4};
    tbl[13] = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h4};

    reset           = 1'b0;
    imem_req_ready  = 1'b1;
    instr_ready     = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    #2;

    // streaming: first valid at cycle 2, then one per cycle in PC order
    do_reset(4);
    lat = 1;
    first = -1;
    npop = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_iv && first < 0) first = cyc - 1;
      if (s_pop) begin
        chk("t1_pc_seq", s_pop_pc, 32'(4 * npop));
        npop++;
      end
    end
    chk("t1_first_valid_cycle", 32'(first), 32'd2);
    chk("t1_throughput", 32'(npop), 32'd18);

    // credit limit under backpressure
    do_reset(4);
    lat = 1;
    for (int i = 0; i < 14; i++) begin
      instr_ready = tbl[i].ir;
      step();
      chk($sformatf("t2_req_valid[%0d]", i), 32'(s_rv), 32'(tbl[i].rv));
      chk($sformatf("t2_req_addr[%0d]", i), s_addr, tbl[i].addr);
      chk($sformatf("t2_instr_valid[%0d]", i), 32'(s_iv), 32'(tbl[i].iv));
      chk($sformatf("t2_instr_pc[%0d]", i), s_pc, tbl[i].pc);
      chk($sformatf("t2_instr[%0d]", i), s_instr, tbl[i].iv ? (tbl[i].pc ^ K) : 32'h0);
    end

    // redirect with two requests in flight on a 3-cycle memory
    do_reset(4);
    lat = 3;
    instr_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    chk("t3_no_req_in_redirect", 32'(s_rv), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("t3_target_req_valid", 32'(s_rv), 32'd1);
    chk("t3_target_req_addr", s_addr, 32'h100);
    first = -1;
    first_pc = '0;
    for (int i = 0; i < 20 && first < 0; i++) begin
      step();
      if (s_iv) begin
        first = cyc - 1;
        first_pc = s_pc;
      end
    end
    chk("t3_first_valid_cycle", 32'(first), 32'd7);
    chk("t3_first_pc", first_pc, 32'h100);
    step();
    chk("t3_second_pc", s_pc, 32'h104);

    // redirect coinciding with a response and a pop
    do_reset(4);
    lat = 1;
    instr_ready = 1'b1;
    repeat (5) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    chk("t4_valid_in_redirect", 32'(s_iv), 32'd1);
    chk("t4_no_req_in_redirect", 32'(s_rv), 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("t4_flushed", 32'(s_iv), 32'd0);
    chk("t4_target_req_valid", 32'(s_rv), 32'd1);
    chk("t4_target_req_addr", s_addr, 32'h200);
    step();
    chk("t4_still_empty", 32'(s_iv), 32'd0);
    step();
    chk("t4_target_valid", 32'(s_iv), 32'd1);
    chk("t4_target_pc", s_pc, 32'h200);

    // random imem stalls, random latency, random consumer stalls
    do_reset(4);
    rand_lat = 1'b1;
    npop = 0;
    nreq = 0;
    prev_stall = 1'b0;
    prev_addr = '0;
    for (int i = 0; i < 3000 && npop < 200; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      instr_ready    = ($urandom_range(0, 3) != 0);
      step();
      if (prev_stall) begin
        chk("t5_valid_held", 32'(s_rv), 32'd1);
        chk("t5_addr_held", s_addr, prev_addr);
      end
      prev_stall = s_rv && !imem_req_ready;
      prev_addr  = s_addr;
      if (s_fire) begin
        chk("t5_req_seq", s_addr, 32'(4 * nreq));
        nreq++;
      end
      if (s_pop) begin
        chk("t5_pop_seq", s_pop_pc, 32'(4 * npop));
        npop++;
      end
    end
    chk("t5_delivered", 32'(npop), 32'd200);
    rand_lat = 1'b0;
    imem_req_ready = 1'b1;

    // reset with two buffered and two in flight
    do_reset(4);
    lat = 3;
    instr_ready = 1'b0;
    repeat (5) step();
    chk("t6_credits_full", 32'(s_rv), 32'd0);
    chk("t6_buffered_valid", 32'(s_iv), 32'd1);
    do_reset(4);
    lat = 1;
    instr_ready = 1'b1;
    step();
    chk("t6_restart_req_valid", 32'(s_rv), 32'd1);
    chk("t6_restart_addr", s_addr, 32'h0);
    step();
    chk("t6_no_stale_valid", 32'(s_iv), 32'd0);
    step();
    chk("t6_first_valid", 32'(s_iv), 32'd1);
    chk("t6_first_pc", s_pc, 32'h0);
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
